alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq_pkg.sv | 25 ++
 rtl/alu_mul_seq_shift.sv | 27 ++
 rtl/alu_mul_seq.sv | 128 ++++++++++++
 tb/tb_alu_mul_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU opcode map and multiply sequencer state encoding.
// MUL_EARLY_EXIT_EN enables the ALIGN early-exit path in the sequencer.
package alu_mul_seq_pkg;

   localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
   localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
   localparam logic [3:0] ALU_OP_AND  = 4'b0010;
   localparam logic [3:0] ALU_OP_OR   = 4'b0011;
   localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
   localparam logic [3:0] ALU_OP_SLL  = 4'b0101;
   localparam logic [3:0] ALU_OP_SRL  = 4'b0110;
   localparam logic [3:0] ALU_OP_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OP_SLT  = 4'b1000;
   localparam logic [3:0] ALU_OP_SLTU = 4'b1001;

   localparam int ITER = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      ALIGN = 2'd3
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_shift.sv
// Shift-add datapath: sum select, {hi,lo} shift, optional barrel align.
// MUL_EARLY_EXIT_EN adds the align shifter.
module mul_shift_unit (
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   input  logic [31:0] alu_out,
   input  logic        alu_c,
`ifdef MUL_EARLY_EXIT_EN
   input  logic [5:0]  shamt,
   output logic [63:0] aligned,
`endif
   output logic [31:0] hi_nx,
   output logic [31:0] lo_nx
);

   logic [32:0] sum33;

   // The 33rd bit comes only from the ALU carry so full-range products stay exact.
   assign sum33 = lo[0] ? {alu_c, alu_out} : {1'b0, hi};
   assign hi_nx = sum33[32:1];
   assign lo_nx = {sum33[0], lo[31:1]};

`ifdef MUL_EARLY_EXIT_EN
   assign aligned = {hi, lo} >> shamt;
`endif

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle 32x32 unsigned shift-add multiplier driving the shared ALU.
// MUL_EARLY_EXIT_EN enables the ALIGN early-exit path.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] mcand,
   input  logic [31:0] mplier,
   output logic        busy,
   output logic        done,
   output logic [63:0] product,
   output logic        z_flag,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_out,
   input  logic        alu_c
);

   mul_state_t  state, state_nx;
   logic [31:0] hi, lo, mcand_r;
   logic [5:0]  count;
   logic [31:0] hi_run, lo_run;

`ifdef MUL_EARLY_EXIT_EN
   logic [5:0]  shamt;
   logic [63:0] aligned;
   logic [31:0] rest_mask;
   logic        rest_zero;

   // Bits of lo still holding unprocessed multiplier bits after this iteration.
   assign rest_mask = 32'hFFFF_FFFF >> (count + 6'd1);
   assign rest_zero = (lo_run & rest_mask) == 32'd0;
   assign shamt     = 6'(ITER) - count;
`endif

   mul_shift_unit u_shift (
      .hi      (hi),
      .lo      (lo),
      .alu_out (alu_out),
      .alu_c   (alu_c),
`ifdef MUL_EARLY_EXIT_EN
      .shamt   (shamt),
      .aligned (aligned),
`endif
      .hi_nx   (hi_run),
      .lo_nx   (lo_run)
   );

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_comb begin
      state_nx = state;
      alu_a    = 32'd0;
      alu_b    = 32'd0;
      alu_op   = ALU_OP_ADD;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef MUL_EARLY_EXIT_EN
               state_nx = (mplier == 32'd0) ? ALIGN : RUN;
`else
               state_nx = RUN;
`endif
            end
         end
         RUN: begin
            alu_a = hi;
            alu_b = mcand_r;
            if (count == 6'(ITER - 1))
               state_nx = DONE;
`ifdef MUL_EARLY_EXIT_EN
            else if (rest_zero)
               state_nx = ALIGN;
`endif
         end
         ALIGN:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         hi      <= 32'd0;
         lo      <= 32'd0;
         mcand_r <= 32'd0;
         count   <= 6'd0;
         product <= 64'd0;
         z_flag  <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand_r <= mcand;
                  hi      <= 32'd0;
                  lo      <= mplier;
                  count   <= 6'd0;
               end
            end
            RUN: begin
               hi    <= hi_run;
               lo    <= lo_run;
               count <= count + 6'd1;
               if (state_nx == DONE) begin
                  product <= {hi_run, lo_run};
                  z_flag  <= ({hi_run, lo_run} == 64'd0);
               end
            end
`ifdef MUL_EARLY_EXIT_EN
            ALIGN: begin
               hi      <= aligned[63:32];
               lo      <= aligned[31:0];
               product <= aligned;
               z_flag  <= (aligned == 64'd0);
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU on the alu_* ports.
// MUL_EARLY_EXIT_EN selects the early-exit latency expectations.
module tb_alu_mul_seq;
   import alu_mul_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] mcand, mplier;
   logic        busy, done, z_flag;
   logic [63:0] product;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [3:0]  alu_op;
   logic        alu_c;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   alu_mul_seq dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mcand   (mcand),
      .mplier  (mplier),
      .busy    (busy),
      .done    (done),
      .product (product),
      .z_flag  (z_flag),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_op  (alu_op),
      .alu_out (alu_out),
      .alu_c   (alu_c)
   );

   always_comb begin
      alu_out = 32'd0;
      alu_c   = 1'b0;
      case (alu_op)
         ALU_OP_ADD: {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         ALU_OP_SUB: {alu_c, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
         ALU_OP_AND: alu_out = alu_a & alu_b;
         ALU_OP_OR:  alu_out = alu_a | alu_b;
         ALU_OP_XOR: alu_out = alu_a ^ alu_b;
         default:    alu_out = 32'd0;
      endcase
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      logic        z;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
      int m = -1;
      for (int i = 0; i < 32; i++)
         if (b[i]) m = i;
      if (m < 0) return 1;
      if (m == 31) return 32;
      return m + 2;
`else
      return 32;
`endif
   endfunction

   // Returns edges from acceptance until done is seen, plus captured result.
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] p,
                         output logic z, output logic busy_ok);
      @(negedge clk);
      start = 1'b1; mcand = a; mplier = b;
      @(negedge clk);
      start = 1'b0; mcand = 32'hDEAD_0000; mplier = 32'h0BAD_0000;
      lat = 0;
      busy_ok = 1'b1;
      while (!done && lat < 100) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!busy) busy_ok = 1'b0;
      p = product;
      z = z_flag;
   endtask

   initial begin
      int          lat;
      logic [63:0] p;
      logic        z, bok;
      int          pulses;

      vt[0]  = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 1'b0};
      vt[1]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1'b0};
      vt[2]  = '{32'h1234_5678,  32'd0,          64'h0,                   1'b1};
      vt[3]  = '{32'd0,          32'd7,          64'h0,                   1'b1};
      vt[4]  = '{32'd1,          32'd1,          64'h1,                   1'b0};
      vt[5]  = '{32'd2,          32'h8000_0000,  64'h0000_0001_0000_0000, 1'b0};
      vt[6]  = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF, 1'b0};
      vt[7]  = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 1'b0};
      vt[8]  = '{32'hDEAD_BEEF,  32'h10,         64'h0000_000D_EADB_EEF0, 1'b0};
      vt[9]  = '{32'd7,          32'd6,          64'h2A,                  1'b0};
      vt[10] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b0};

      reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_product", product, 64'd0);
      chk("rst_z", 64'(z_flag), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'(ALU_OP_ADD));
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         do_mul(vt[i].a, vt[i].b, lat, p, z, bok);
         chk($sformatf("v%0d_product", i), p, vt[i].p);
         chk($sformatf("v%0d_z", i), 64'(z), 64'(vt[i].z));
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat(vt[i].b)));
         chk($sformatf("v%0d_busy", i), 64'(bok), 64'd1);
         @(negedge clk);
         chk($sformatf("v%0d_pulse", i), 64'(done), 64'd0);
         chk($sformatf("v%0d_idle", i), 64'(busy), 64'd0);
         chk($sformatf("v%0d_hold", i), product, vt[i].p);
      end

      // start re-asserted while running is ignored
      @(negedge clk);
      start = 1'b1; mcand = 32'd7; mplier = 32'd11;
      @(negedge clk);
      start = 1'b0;
      chk("run_alu_b", 64'(alu_b), 64'd7);
      chk("run_alu_op", 64'(alu_op), 64'(ALU_OP_ADD));
      @(negedge clk);
      start = 1'b1; mcand = 32'd9; mplier = 32'd9;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      p = '0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            p = product;
         end
      end
      chk("ignore_product", p, 64'd77);
      chk("ignore_pulses", 64'(pulses), 64'd1);

      // reset mid-operation aborts without a done pulse
      @(negedge clk);
      start = 1'b1; mcand = 32'h1234; mplier = 32'hFFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_busy_pre", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_product", product, 64'd0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("abort_no_done", 64'(pulses), 64'd0);
      do_mul(32'd2, 32'd3, lat, p, z, bok);
      chk("after_abort_product", p, 64'd6);
      chk("after_abort_latency", 64'(lat), 64'(exp_lat(32'd3)));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
